jpeg_frame_store: RTL and testbench

Capture-side image buffer directly downstream of the JPEG encoder top level. Accepts the encoder's 32-bit word stream with byte addresses, writes it into an on-chip single-port RAM, and latches the final compressed size when the encoder flags image completion. A host-side read port, typically the SPI register bank, fetches stored words. Encoder writes take priority over reads.

---
 rtl/jpeg_frame_store_pkg.sv | 20 ++
 rtl/jfs_ram.sv | 29 ++
 rtl/jpeg_frame_store.sv | 161 ++++++++++++++++
 tb/tb_jpeg_frame_store.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_frame_store_pkg.sv
// Shared types and constants for the JPEG frame store: capture FSM states,
// the byte-address bit where the word index starts, and the 16-bit size clamp.
package jpeg_frame_store_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Byte address bit 2 upward selects the 32-bit word.
    localparam int WORD_LSB = 2;

    // Reported size is 16 bits wide; anything larger saturates.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/jfs_ram.sv
// Single-port 32-bit RAM with synchronous, write-first read.
// Shaped so synthesis maps it onto embedded block RAM.
module jfs_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // One access per cycle; a write also presents the new word on the read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_frame_store.sv
// Capture buffer behind the JPEG encoder: stores the encoder word stream,
// tracks the compressed size, flags dropped words, and serves host reads.
//
// Read handshake: read_request_in is a one-cycle request, accepted only when
// no read is pending; the index is latched on acceptance. The request goes to
// the RAM on the first cycle without an encoder write, and read_valid_out
// pulses one cycle later with read_data_out, which then holds until the next
// completed read.
module jpeg_frame_store
    import jpeg_frame_store_pkg::*;
#(
    parameter int BUFFER_BYTES = 16384,
    parameter int AW           = $clog2(BUFFER_BYTES / 4)
) (
    input  logic          pixel_clock_in,
    input  logic          pixel_reset_in,
    input  logic          start_capture_in,
    input  logic [31:0]   data_in,
    input  logic [15:0]   address_in,
    input  logic          data_valid_in,
    input  logic          image_valid_in,
    input  logic [AW-1:0] read_address_in,
    input  logic          read_request_in,
    output logic [31:0]   read_data_out,
    output logic          read_valid_out,
    output logic [15:0]   image_size_out,
    output logic          image_ready_out,
    output logic          overflow_out,
    output logic [1:0]    state_dbg_out
);

    localparam logic [16:0] BUF_LIMIT = 17'(BUFFER_BYTES);

    state_t        state_q, state_d;
    logic          image_valid_q;
    logic [16:0]   run_size_q, run_size_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   image_size_q, image_size_d;

    logic          pending_q;
    logic          issued_q;
    logic [AW-1:0] rd_addr_q;
    logic [31:0]   read_data_q;
    logic          read_valid_q;

    logic          accept_window;
    logic          addr_ok;
    logic          ram_we;
    logic          image_rise;
    logic          issue;
    logic [16:0]   word_end;
    logic [16:0]   final_size;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign accept_window = (state_q == ARMED) || (state_q == CAPTURING);
    assign addr_ok       = {1'b0, address_in} < BUF_LIMIT;
    assign ram_we        = accept_window && data_valid_in && addr_ok;
    assign image_rise    = image_valid_in && !image_valid_q;
    assign word_end      = {1'b0, address_in} + 17'd4;
    assign wr_idx        = address_in[AW+1:WORD_LSB];
    // Encoder writes own the single RAM port; a pending read waits for a gap.
    assign issue         = pending_q && !ram_we;
    assign ram_addr      = ram_we ? wr_idx : rd_addr_q;

    // Next-state, size tracking and overflow detection.
    always_comb begin
        state_d      = state_q;
        run_size_d   = run_size_q;
        overflow_d   = overflow_q;
        image_size_d = image_size_q;
        final_size   = 17'd0;
        if (start_capture_in) begin
            state_d      = ARMED;
            run_size_d   = 17'd0;
            overflow_d   = 1'b0;
            image_size_d = 16'd0;
        end else begin
            if (accept_window && data_valid_in) begin
                if (!addr_ok) begin
                    overflow_d = 1'b1;
                end else if (word_end > run_size_q) begin
                    run_size_d = word_end;
                end
            end
            // Size includes a word written in the same cycle as the image edge.
            final_size = (overflow_d && run_size_d > BUF_LIMIT) ? BUF_LIMIT : run_size_d;
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (data_valid_in) state_d = CAPTURING;
                end
                CAPTURING: begin
                    if (image_rise) begin
                        state_d      = DONE;
                        image_size_d = sat16(final_size);
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Capture FSM and size/overflow registers.
    always_ff @(posedge pixel_clock_in) begin
        if (pixel_reset_in) begin
            state_q       <= IDLE;
            image_valid_q <= 1'b0;
            run_size_q    <= 17'd0;
            overflow_q    <= 1'b0;
            image_size_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            image_valid_q <= image_valid_in;
            run_size_q    <= run_size_d;
            overflow_q    <= overflow_d;
            image_size_q  <= image_size_d;
        end
    end

    // Read arbiter: hold one request, issue it on a write-free cycle, return data.
    always_ff @(posedge pixel_clock_in) begin
        if (pixel_reset_in) begin
            pending_q    <= 1'b0;
            issued_q     <= 1'b0;
            rd_addr_q    <= '0;
            read_data_q  <= 32'd0;
            read_valid_q <= 1'b0;
        end else begin
            issued_q     <= issue;
            read_valid_q <= issued_q;
            if (issued_q) read_data_q <= ram_rdata;
            if (issue) pending_q <= 1'b0;
            if (read_request_in && !pending_q) begin
                pending_q <= 1'b1;
                rd_addr_q <= read_address_in;
            end
        end
    end

    jfs_ram #(
        .DEPTH (BUFFER_BYTES / 4),
        .AW    (AW)
    ) u_ram (
        .clk_i   (pixel_clock_in),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_in),
        .rdata_o (ram_rdata)
    );

    assign read_data_out   = read_data_q;
    assign read_valid_out  = read_valid_q;
    assign image_size_out  = image_size_q;
    assign image_ready_out = (state_q == DONE);
    assign overflow_out    = overflow_q;
    assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_jpeg_frame_store.sv
// Self-checking bench for jpeg_frame_store with a 1 KiB buffer: directed
// scenarios with literal expectations plus randomized traffic, all checked
// every cycle against a behavioural model of the frame store.
module tb_jpeg_frame_store;

    localparam int BB    = 1024;
    localparam int WORDS = BB / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data;
    logic [15:0] addr;
    logic        dv;
    logic        iv;
    logic [7:0]  rd_addr;
    logic        req;
    logic [31:0] read_data_out;
    logic        read_valid_out;
    logic [15:0] image_size_out;
    logic        image_ready_out;
    logic        overflow_out;
    logic [1:0]  state_dbg_out;

    int tests = 0;
    int fails = 0;

    jpeg_frame_store #(.BUFFER_BYTES(BB)) dut (
        .pixel_clock_in   (clk),
        .pixel_reset_in   (rst),
        .start_capture_in (start),
        .data_in          (data),
        .address_in       (addr),
        .data_valid_in    (dv),
        .image_valid_in   (iv),
        .read_address_in  (rd_addr),
        .read_request_in  (req),
        .read_data_out    (read_data_out),
        .read_valid_out   (read_valid_out),
        .image_size_out   (image_size_out),
        .image_ready_out  (image_ready_out),
        .overflow_out     (overflow_out),
        .state_dbg_out    (state_dbg_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // Capture phase: 0 idle, 1 armed, 2 capturing, 3 done.
    int          m_phase = 0;
    int          m_size = 0;
    bit          m_ovf = 0;
    bit          m_iv_prev = 0;
    logic [31:0] m_mem [WORDS];
    bit          m_rd_wait = 0;    // request accepted, waiting for a write-free edge
    bit          m_rd_fetched = 0; // word fetched, result appears at next edge
    int          m_rd_idx = 0;
    logic [31:0] m_rd_word = 0;
    bit          started = 0;

    logic [31:0] e_data = 0;
    bit          e_valid = 0;
    logic [15:0] e_size = 0;
    bit          e_ready = 0;
    bit          e_ovf = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_phase = 0; m_size = 0; m_ovf = 0; m_iv_prev = 0;
            m_rd_wait = 0; m_rd_fetched = 0;
            e_data = 0; e_valid = 0; e_size = 0; e_ready = 0; e_ovf = 0;
            exp_q.delete();
        end else begin : mdl
            bit wrote;
            bit was_waiting;
            bit rise;
            int old_phase;
            int fin;
            wrote = 0;
            e_valid = 0;
            if (m_rd_fetched) begin
                e_valid = 1;
                e_data = m_rd_word;
                exp_q.push_back(m_rd_word);
                m_rd_fetched = 0;
            end
            rise = iv && !m_iv_prev;
            m_iv_prev = iv;
            old_phase = m_phase;
            if (start) begin
                m_phase = 1; m_size = 0; m_ovf = 0; e_size = 0;
            end else begin
                if ((old_phase == 1 || old_phase == 2) && dv) begin
                    if (int'(addr) >= BB) begin
                        m_ovf = 1;
                    end else begin
                        m_mem[int'(addr) / 4] = data;
                        wrote = 1;
                        if (int'(addr) + 4 > m_size) m_size = int'(addr) + 4;
                    end
                end
                if (old_phase == 1 && dv) m_phase = 2;
                if (old_phase == 2 && rise) begin
                    m_phase = 3;
                    fin = (m_ovf && m_size > BB) ? BB : m_size;
                    e_size = (fin > 65535) ? 16'hFFFF : 16'(fin);
                end
            end
            was_waiting = m_rd_wait;
            if (was_waiting && !wrote) begin
                m_rd_word = m_mem[m_rd_idx];
                m_rd_fetched = 1;
                m_rd_wait = 0;
            end
            if (req && !was_waiting) begin
                m_rd_wait = 1;
                m_rd_idx = int'(rd_addr);
            end
            e_ready = (m_phase == 3);
            e_ovf = m_ovf;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("read_valid", 32'(read_valid_out), 32'(e_valid));
            chk("read_data", read_data_out, e_data);
            chk("image_size", 32'(image_size_out), 32'(e_size));
            chk("image_ready", 32'(image_ready_out), 32'(e_ready));
            chk("overflow", 32'(overflow_out), 32'(e_ovf));
            if (read_valid_out) begin
                if (exp_q.size() == 0) chk("read_unexpected", 32'(read_valid_out), 32'd0);
                else chk("read_sb", read_data_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] wdat [WORDS];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1; cyc(); start = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic ivv);
        dv = 1; addr = a; data = d; iv = ivv;
        if (int'(a) < BB) wdat[int'(a) / 4] = d;
        cyc();
        dv = 0;
    endtask

    task automatic do_read(input int idx, output logic [31:0] d, output int lat);
        bit found;
        found = 0; lat = 0; d = 0;
        rd_addr = 8'(idx); req = 1; cyc(); req = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(); lat++;
            if (read_valid_out) begin found = 1; d = read_data_out; end
        end
        chk("read_timeout", 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] d_last;
        logic [31:0] burst5;
        int lat;
        bit seen;

        rst = 1; start = 0; data = 0; addr = 0; dv = 0; iv = 0; rd_addr = 0; req = 0;
        repeat (3) cyc();
        rst = 0; cyc();
        chk("reset_size", 32'(image_size_out), 32'd0);
        chk("reset_ready", 32'(image_ready_out), 32'd0);
        chk("reset_ovf", 32'(overflow_out), 32'd0);
        chk("reset_valid", 32'(read_valid_out), 32'd0);
        chk("reset_data", read_data_out, 32'd0);

        // Fill every word so later reads always hit defined data.
        pulse_start();
        for (int i = 0; i < WORDS; i++) wr(16'(i * 4), $urandom, 1'b0);
        pulse_start();
        chk("fill_restart_size", 32'(image_size_out), 32'd0);

        // Basic capture of 64 words.
        pulse_start();
        for (int i = 0; i < 64; i++) wr(16'(i * 4), $urandom, 1'b0);
        iv = 1; cyc();
        chk("basic_ready", 32'(image_ready_out), 32'd1);
        chk("basic_size", 32'(image_size_out), 32'd256);
        chk("basic_ovf", 32'(overflow_out), 32'd0);
        for (int i = 0; i < 64; i++) begin
            do_read(i, d, lat);
            chk("basic_rd", d, wdat[i]);
            chk("basic_lat", 32'(lat), 32'd2);
            repeat ($urandom_range(0, 2)) cyc();
        end
        iv = 0; cyc();

        // Overflow: two out-of-range words dropped, last in-range word intact.
        pulse_start();
        wr(16'h03F8, $urandom, 1'b0);
        d_last = $urandom;
        wr(16'h03FC, d_last, 1'b0);
        wr(16'h0400, $urandom, 1'b0);
        wr(16'h0404, $urandom, 1'b0);
        iv = 1; cyc();
        chk("ovf_flag", 32'(overflow_out), 32'd1);
        chk("ovf_size", 32'(image_size_out), 32'd1024);
        chk("ovf_ready", 32'(image_ready_out), 32'd1);
        do_read(255, d, lat);
        chk("ovf_word255", d, d_last);
        iv = 0; cyc();

        // Arbitration: read held off by a 10-cycle write burst; second request ignored.
        pulse_start();
        burst5 = 0;
        for (int k = 0; k < 10; k++) begin
            dv = 1; addr = 16'(k * 4); data = $urandom;
            wdat[k] = data;
            if (k == 5) burst5 = data;
            req = (k == 0 || k == 4);
            if (k == 0) rd_addr = 8'd5;
            if (k == 4) rd_addr = 8'd9;
            cyc();
        end
        dv = 0; req = 0; rd_addr = 8'd5;
        seen = 0; lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc(); lat++;
            if (read_valid_out) begin seen = 1; d = read_data_out; end
        end
        chk("arb_seen", 32'(seen), 32'd1);
        chk("arb_lat", 32'(lat), 32'd2);
        chk("arb_data", d, burst5);

        // Last word in the same cycle as the image edge.
        pulse_start();
        for (int i = 0; i < 4; i++) wr(16'(i * 4), $urandom, 1'b0);
        wr(16'h0010, $urandom, 1'b1);
        chk("simul_size", 32'(image_size_out), 32'd20);
        chk("simul_ready", 32'(image_ready_out), 32'd1);
        iv = 0; cyc();

        // Restart mid-capture.
        pulse_start();
        for (int i = 0; i < 8; i++) wr(16'(i * 4), $urandom, 1'b0);
        pulse_start();
        chk("restart_size", 32'(image_size_out), 32'd0);
        chk("restart_ready", 32'(image_ready_out), 32'd0);
        for (int i = 0; i < 4; i++) wr(16'(i * 4), $urandom, 1'b0);
        iv = 1; cyc();
        chk("restart_size4", 32'(image_size_out), 32'd16);
        iv = 0; cyc();

        // Reset the cycle after a read request.
        rd_addr = 8'd3; req = 1; cyc(); req = 0;
        rst = 1; cyc(); cyc(); rst = 0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (read_valid_out) seen = 1;
        end
        chk("rstrd_novalid", 32'(seen), 32'd0);
        chk("rstrd_data", read_data_out, 32'd0);
        chk("rstrd_size", 32'(image_size_out), 32'd0);
        chk("rstrd_ready", 32'(image_ready_out), 32'd0);
        chk("rstrd_ovf", 32'(overflow_out), 32'd0);

        // Randomized traffic checked cycle-by-cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 799) == 0);
            dv = ($urandom_range(0, 2) != 0);
            addr = ($urandom_range(0, 9) == 0) ? 16'(($urandom_range(256, 330)) * 4)
                                               : 16'(($urandom_range(0, 255)) * 4);
            data = $urandom;
            start = !dv && ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) iv = !iv;
            req = 0;
            if (!m_rd_wait && !m_rd_fetched && $urandom_range(0, 3) == 0) begin
                req = 1;
                rd_addr = 8'($urandom_range(0, 255));
            end
            cyc();
        end
        rst = 0; dv = 0; start = 0; req = 0; iv = 0;
        repeat (30) cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
